// File: rtl/etapa_fetch_pkg.sv
// -----------------------------------------------------------------------------
// etapa_fetch_pkg
// Shared definitions for the instruction fetch stage:
//   - state_t   : fetch FSM state encodings (IDLE, REQ, DROP)
//   - RESET_PC_DEF : default first fetch address after reset
//   - INSTR_W   : instruction word width
//   - OP_HI/OP_LO : opcode field position inside an instruction word
//   - op_of()   : extracts the opcode field from an instruction word
// -----------------------------------------------------------------------------
package etapa_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DROP = 2'd2
   } state_t;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam int          INSTR_W      = 32;
   localparam int          OP_HI        = 31;
   localparam int          OP_LO        = 26;
   localparam int          OP_W         = OP_HI - OP_LO + 1;

   function automatic logic [OP_W-1:0] op_of(input logic [INSTR_W-1:0] instr);
      return instr[OP_HI:OP_LO];
   endfunction

endpackage

// File: rtl/etapa_fetch_fifo.sv
// -----------------------------------------------------------------------------
// fifo_instr
// Small synchronous FIFO holding fetched {pc, instruction} pairs.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (pointers/count only)
//   push        : write push_data (ignored when full)
//   push_data   : entry to write
//   pop         : drop the head entry (ignored when empty)
//   flush       : empty the FIFO; wins over push and pop
//   full, empty : occupancy flags
//   count       : number of stored entries (0..DEPTH)
//   head        : oldest entry, meaningful only when !empty
// -----------------------------------------------------------------------------
module fifo_instr #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic [WIDTH-1:0]         head
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // Storage carries no reset; validity is tracked entirely by count.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= push_data;
   end

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

endmodule

// File: rtl/etapa_fetch.sv
// -----------------------------------------------------------------------------
// etapa_fetch
// Instruction fetch stage: issues word-aligned reads to instruction memory,
// buffers returned words with their addresses, and hands them to decode.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   imem_req / imem_addr    : read request and its byte address (held until ack)
//   imem_ack / imem_rdata   : request accepted, data valid in the same cycle
//   redirect / redirect_pc  : taken branch/jump; flush and refetch from target
//   if_valid / if_instr / if_pc / if_op : instruction offered to decode
//   if_ready                : decode consumes the offered instruction
// -----------------------------------------------------------------------------
module etapa_fetch
   import etapa_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter int          DEPTH    = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_req,
   output logic [31:0]        imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               redirect,
   input  logic [31:0]        redirect_pc,
   output logic               if_valid,
   output logic [INSTR_W-1:0] if_instr,
   output logic [31:0]        if_pc,
   output logic [OP_W-1:0]    if_op,
   input  logic               if_ready
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   state_t             state, state_nxt;
   logic [31:0]        pc, pc_nxt;
   logic [31:0]        drop_addr, drop_addr_nxt;
   logic [31:0]        redirect_tgt;
   logic               push, pop, flush;
   logic               full, empty;
   logic [CNT_W-1:0]   count, count_after;
   logic [63:0]        head;

   assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
   assign pop          = !empty && if_ready;
   // Occupancy once the word accepted this cycle lands; a slot was reserved
   // on entry to REQ, so count is at most DEPTH-1 here and this cannot wrap.
   assign count_after  = count + CNT_W'(1) - CNT_W'(pop);

   always_comb begin
      state_nxt     = state;
      pc_nxt        = pc;
      drop_addr_nxt = drop_addr;
      push          = 1'b0;
      flush         = 1'b0;
      unique case (state)
         IDLE: begin
            if (redirect) begin
               flush  = 1'b1;
               pc_nxt = redirect_tgt;
            end else if (!full) begin
               state_nxt = REQ;
            end
         end
         REQ: begin
            if (redirect) begin
               flush  = 1'b1;
               pc_nxt = redirect_tgt;
               // The in-flight read cannot be withdrawn: keep presenting the
               // old address in DROP and throw its data away.
               if (!imem_ack) begin
                  state_nxt     = DROP;
                  drop_addr_nxt = pc;
               end
            end else if (imem_ack) begin
               push      = 1'b1;
               pc_nxt    = pc + 32'd4;
               state_nxt = (count_after < DEPTH_C) ? REQ : IDLE;
            end
         end
         DROP: begin
            if (redirect) begin
               flush  = 1'b1;
               pc_nxt = redirect_tgt;
            end
            if (imem_ack) state_nxt = REQ;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         pc    <= RESET_PC;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
      end
   end

   always_ff @(posedge clk) begin
      drop_addr <= drop_addr_nxt;
   end

   fifo_instr #(
      .DEPTH (DEPTH),
      .WIDTH (64)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data ({pc, imem_rdata}),
      .pop       (pop),
      .flush     (flush),
      .full      (full),
      .empty     (empty),
      .count     (count),
      .head      (head)
   );

   assign imem_req  = (state == REQ) || (state == DROP);
   assign imem_addr = (state == DROP) ? drop_addr : pc;

   // Outputs read as zero while nothing is buffered, so reset and flush
   // present a clean bus without resetting the storage array.
   assign if_valid = !empty;
   assign if_instr = empty ? '0 : head[31:0];
   assign if_pc    = empty ? '0 : head[63:32];
   assign if_op    = op_of(if_instr);

endmodule

// File: tb/tb_etapa_fetch.sv
module tb_etapa_fetch;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [5:0]  if_op;
   logic        if_ready;

   int checks = 0;
   int errors = 0;

   // Memory returns a word derived from the address it is asked for.
   assign imem_rdata = imem_addr ^ 32'hDEAD_0000;

   etapa_fetch #(
      .RESET_PC (32'h0000_0000),
      .DEPTH    (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .if_valid    (if_valid),
      .if_instr    (if_instr),
      .if_pc       (if_pc),
      .if_op       (if_op),
      .if_ready    (if_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst_n       = 1'b0;
      imem_ack    = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      if_ready    = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset;
      rst_n       = 1'b0;
      imem_ack    = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      if_ready    = 1'b0;
      tick();
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %0h exp 0", imem_req); end
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h exp 0", if_valid); end
      checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h exp 0", if_instr); end
      checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", if_pc); end
      rst_n = 1'b1;
      tick();
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rel_req got %0h exp 1", imem_req); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rel_addr got %h exp 0", imem_addr); end
   endtask

   task automatic test_stream;
      do_reset();
      imem_ack = 1'b1;
      if_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL stream_req[%0d] got %0h exp 1", i, imem_req); end
         checks++; if (imem_addr !== 32'(4 * i)) begin errors++; $display("FAIL stream_addr[%0d] got %h exp %h", i, imem_addr, 32'(4 * i)); end
         if (i > 0) begin
            checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %0h exp 1", i, if_valid); end
            checks++; if (if_pc !== 32'(4 * (i - 1))) begin errors++; $display("FAIL stream_pc[%0d] got %h exp %h", i, if_pc, 32'(4 * (i - 1))); end
            checks++; if (if_instr !== (32'hDEAD_0000 ^ 32'(4 * (i - 1)))) begin errors++; $display("FAIL stream_instr[%0d] got %h exp %h", i, if_instr, 32'hDEAD_0000 ^ 32'(4 * (i - 1))); end
         end else begin
            checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL stream_valid0 got %0h exp 0", if_valid); end
         end
         tick();
      end
      imem_ack = 1'b0;
   endtask

   task automatic test_stall;
      do_reset();
      imem_ack = 1'b1;
      if_ready = 1'b0;
      tick();
      checks++; if (if_pc !== 32'h0 || if_valid !== 1'b1) begin errors++; $display("FAIL stall_first got %0h/%h exp 1/0", if_valid, if_pc); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL stall_req1 got %0h/%h exp 1/4", imem_req, imem_addr); end
      tick();
      imem_ack = 1'b0;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req_drop got %0h exp 0", imem_req); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'hDEAD_0000) begin errors++; $display("FAIL stall_hold[%0d] got %0h/%h/%h exp 1/0/dead0000", i, if_valid, if_pc, if_instr); end
         tick();
         checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_noreq[%0d] got %0h exp 0", i, imem_req); end
      end
      if_ready = 1'b1;
      tick();
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'h4) begin errors++; $display("FAIL stall_second got %0h/%h exp 1/4", if_valid, if_pc); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req_full got %0h exp 0", imem_req); end
      tick();
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL stall_drained got %0h exp 0", if_valid); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL stall_resume got %0h/%h exp 1/8", imem_req, imem_addr); end
      if_ready = 1'b0;
   endtask

   task automatic test_delay;
      do_reset();
      if_ready = 1'b1;
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin errors++; $display("FAIL delay_first got %0h/%h exp 1/0", if_valid, if_pc); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL delay_addr[%0d] got %0h/%h exp 1/4", i, imem_req, imem_addr); end
         tick();
         checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL delay_nopush[%0d] got %0h exp 0", i, if_valid); end
      end
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_instr !== 32'hDEAD_0004) begin errors++; $display("FAIL delay_push got %0h/%h/%h exp 1/4/dead0004", if_valid, if_pc, if_instr); end
      checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL delay_next got %h exp 8", imem_addr); end
      tick();
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL delay_single got %0h exp 0", if_valid); end
   endtask

   task automatic test_redirect_drop;
      do_reset();
      if_ready    = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0100;
      tick();
      redirect = 1'b0;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL drop_hold got %0h/%h exp 1/0", imem_req, imem_addr); end
      tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL drop_hold2 got %0h/%h exp 1/0", imem_req, imem_addr); end
      imem_ack = 1'b1;
      tick();
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL drop_discard got %0h exp 0", if_valid); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL drop_target got %0h/%h exp 1/100", imem_req, imem_addr); end
      tick();
      imem_ack = 1'b0;
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== 32'hDEAD_0100) begin errors++; $display("FAIL drop_first got %0h/%h/%h exp 1/100/dead0100", if_valid, if_pc, if_instr); end
      checks++; if (if_op !== 6'h37) begin errors++; $display("FAIL drop_op got %h exp 37", if_op); end
   endtask

   task automatic test_drop_retarget;
      do_reset();
      if_ready    = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0100;
      tick();
      redirect_pc = 32'h0000_0300;
      tick();
      redirect = 1'b0;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL retarget_hold got %0h/%h exp 1/0", imem_req, imem_addr); end
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      checks++; if (imem_addr !== 32'h300 || if_valid !== 1'b0) begin errors++; $display("FAIL retarget_addr got %h/%0h exp 300/0", imem_addr, if_valid); end
   endtask

   task automatic test_redirect_ack;
      do_reset();
      if_ready    = 1'b1;
      imem_ack    = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0203;
      tick();
      redirect = 1'b0;
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL racq_nopush got %0h exp 0", if_valid); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL racq_addr got %0h/%h exp 1/200", imem_req, imem_addr); end
      tick();
      imem_ack = 1'b0;
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'h200) begin errors++; $display("FAIL racq_push got %0h/%h exp 1/200", if_valid, if_pc); end
   endtask

   task automatic test_flush;
      do_reset();
      imem_ack = 1'b1;
      tick();
      tick();
      imem_ack    = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0040;
      tick();
      redirect = 1'b0;
      checks++; if (if_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL flush_empty got %0h/%0h exp 0/0", if_valid, imem_req); end
      tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("FAIL flush_refetch got %0h/%h exp 1/40", imem_req, imem_addr); end
   endtask

   task automatic test_reset_full;
      do_reset();
      imem_ack = 1'b1;
      tick();
      tick();
      imem_ack = 1'b0;
      checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL rfull_pre got %0h exp 1", if_valid); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (if_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL rfull_async got %0h/%0h exp 0/0", if_valid, imem_req); end
      checks++; if (if_instr !== 32'h0 || if_pc !== 32'h0) begin errors++; $display("FAIL rfull_zero got %h/%h exp 0/0", if_instr, if_pc); end
      tick();
      rst_n = 1'b1;
      tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_valid !== 1'b0) begin errors++; $display("FAIL rfull_refetch got %0h/%h/%0h exp 1/0/0", imem_req, imem_addr, if_valid); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_delay();
      test_redirect_drop();
      test_drop_retarget();
      test_redirect_ack();
      test_flush();
      test_reset_full();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/etapa_fetch.md
ETAPA_FETCH -- requirements
Module: etapa_fetch

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter: DEPTH, 2, instruction buffer entries (power of two, >=2).
REQ-003 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: imem_req  output  1  instruction-memory read request.
REQ-006 SHALL have port: imem_addr  output  32  byte address of request, word aligned.
REQ-007 SHALL have port: imem_ack  input  1  request accepted; imem_rdata valid this cycle.
REQ-008 SHALL have port: imem_rdata  input  32  instruction word.
REQ-009 SHALL have port: redirect  input  1  branch/jump taken; flush and refetch.
REQ-010 SHALL have port: redirect_pc  input  32  new fetch address.
REQ-011 SHALL have port: if_valid  output  1  instruction available to decode.
REQ-012 SHALL have port: if_instr  output  32  instruction word.
REQ-013 SHALL have port: if_pc  output  32  address of if_instr.
REQ-014 SHALL have port: if_op  output  6  if_instr[31:26], drives Unidad_de_Control op.
REQ-015 SHALL have port: if_ready  input  1  decode consumes instruction.

Function
REQ-016 SHALL implement FSM states IDLE, REQ, DROP.
REQ-017 IDLE->REQ when free slots (DEPTH - count - outstanding) > 0 and no redirect; imem_req=1 only in REQ.
REQ-018 In REQ, imem_addr and imem_req SHALL stay stable until imem_ack.
REQ-019 REQ with imem_ack, no redirect: push {pc, imem_rdata}, pc <= pc+4 (mod 2^32); stay REQ if slot remains, else IDLE.
REQ-020 Pushed entry SHALL appear on if_valid/if_instr/if_pc the cycle after imem_ack (one-cycle latency).
REQ-021 if_valid SHALL equal buffer not empty; pop when if_valid && if_ready; push and pop same cycle SHALL both occur, count unchanged.
REQ-022 Buffer full: no new request issued; a request already in REQ SHALL have a reserved slot, never overflow.
REQ-023 Outputs SHALL hold stable while if_valid && !if_ready.
REQ-024 redirect SHALL take priority: flush buffer (if_valid=0 next cycle), pc <= {redirect_pc[31:2],2'b00}.
REQ-025 redirect while REQ without imem_ack: go DROP; DROP deasserts imem_req? No -- DROP SHALL keep imem_req=1, old address, until imem_ack, discard data, then REQ at redirect target.
REQ-026 redirect coincident with imem_ack: data discarded, next state REQ at redirect target.
REQ-027 redirect in DROP: update pc to newest target, remain DROP.
REQ-028 if_op SHALL be purely the bit slice of if_instr.

Reset
REQ-029 rst_n low SHALL asynchronously force state IDLE, pc=RESET_PC, buffer empty, imem_req=0, if_valid=0, if_instr=0, if_pc=0.
REQ-030 Reset mid-request SHALL abandon it; first cycle after release SHALL move to REQ with imem_addr=RESET_PC.

Structure
REQ-031 Shared package SHALL hold FSM state encodings, RESET_PC default, instruction width 32, opcode slice [31:26].
REQ-032 Buffer SHALL be sub-module fifo_instr (DEPTH, width 64, push/pop/flush, full/empty/count).

Verification
REQ-033 Reset release, imem_ack every cycle, if_ready=1 -> addresses 0,4,8,...; if_pc 0 valid cycle after first ack.
REQ-034 if_ready=0 for 5 cycles -> exactly DEPTH=2 words buffered, imem_req drops, if_instr at pc 0 held.
REQ-035 imem_ack delayed 3 cycles -> imem_addr=0x4 stable all 3 cycles, single push.
REQ-036 redirect to 0x100 while REQ outstanding -> DROP, stale word discarded, next req 0x100, if_pc=0x100 first valid.
REQ-037 redirect to 0x203 coincident with imem_ack -> no push, next imem_addr=0x200.
REQ-038 rst_n asserted while buffer holds 2 entries -> if_valid=0 immediately, refetch from RESET_PC.
